// File: rtl/cla_adder_pipe.sv
// Pipelined carry-lookahead adder/subtractor built from 4-bit lookahead groups.
// Each register stage resolves (WIDTH/4)/STAGES groups, LSB first; flags come out of the last stage.
module cla_adder_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NG   = WIDTH / 4;
  localparam int GPS  = NG / STAGES;
  localparam int SW   = 4 * GPS;
  localparam int LAST = STAGES - 1;

  // Result packing: {carry out of slice, carry into slice MSB, slice sum}.
  function automatic logic [SW+1:0] cla_slice(input logic [SW-1:0] x,
                                               input logic [SW-1:0] y,
                                               input logic          ci);
    logic [SW-1:0]  g;
    logic [SW-1:0]  p;
    logic [SW-1:0]  s;
    logic [GPS-1:0] gg;
    logic [GPS-1:0] gp;
    logic [GPS:0]   gc;
    logic [3:0]     c;
    logic           pa;
    logic           cmsb;
    g    = x & y;
    p    = x ^ y;
    s    = '0;
    c    = '0;
    cmsb = 1'b0;
    for (int j = 0; j < GPS; j++) begin
      gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
            | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      gp[j] = &p[4*j +: 4];
    end
    // Flattened group lookahead: carry into group j from every lower G term and the slice carry-in.
    gc    = '0;
    gc[0] = ci;
    for (int j = 1; j <= GPS; j++) begin
      pa = 1'b1;
      for (int k = j - 1; k >= 0; k--) begin
        gc[j] = gc[j] | (pa & gg[k]);
        pa    = pa & gp[k];
      end
      gc[j] = gc[j] | (pa & ci);
    end
    for (int j = 0; j < GPS; j++) begin
      c[0] = gc[j];
      c[1] = g[4*j] | (p[4*j] & c[0]);
      c[2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & c[0]);
      c[3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
           | (p[4*j+2] & p[4*j+1] & p[4*j] & c[0]);
      s[4*j +: 4] = p[4*j +: 4] ^ c;
      cmsb        = c[3];
    end
    return {gc[GPS], cmsb, s};
  endfunction

  logic              advance;
  logic [STAGES-1:0] vld_q, vld_d;
  logic [STAGES-1:0] cy_q, cy_d;
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  sum_d [STAGES];
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  a_d [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  b_d [STAGES];
  logic              ovf_q, ovf_d;
  logic              zero_q, zero_d;

  logic [WIDTH-1:0]  src_a [STAGES];
  logic [WIDTH-1:0]  src_b [STAGES];
  logic [WIDTH-1:0]  src_sum [STAGES];
  logic [STAGES-1:0] src_c;
  logic [STAGES-1:0] src_v;
  logic [SW+1:0]     res [STAGES];

  // Handshake: a beat moves when valid & ready on the same edge. The whole pipe advances
  // together whenever the output slot is empty or being taken, so in_ready mirrors advance.
  assign advance   = ~vld_q[LAST] | out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_q[LAST];
  assign sum       = sum_q[LAST];
  assign cout      = cy_q[LAST];
  assign ovf       = ovf_q;
  assign zero      = zero_q;

  always_comb begin
    src_a[0]   = a;
    src_b[0]   = sub ? ~b : b;
    src_c[0]   = sub | cin;
    src_v[0]   = in_valid;
    src_sum[0] = '0;
    for (int s = 1; s < STAGES; s++) begin
      src_a[s]   = a_q[s-1];
      src_b[s]   = b_q[s-1];
      src_c[s]   = cy_q[s-1];
      src_v[s]   = vld_q[s-1];
      src_sum[s] = sum_q[s-1];
    end
  end

  always_comb begin
    for (int s = 0; s < STAGES; s++) begin
      res[s] = cla_slice(src_a[s][SW-1:0], src_b[s][SW-1:0], src_c[s]);
    end
  end

  // Operands shift right as slices are consumed; sum slices enter at the top and walk down.
  always_comb begin
    vld_d  = vld_q;
    cy_d   = cy_q;
    ovf_d  = ovf_q;
    zero_d = zero_q;
    for (int s = 0; s < STAGES; s++) begin
      sum_d[s] = sum_q[s];
      a_d[s]   = a_q[s];
      b_d[s]   = b_q[s];
    end
    if (advance) begin
      for (int s = 0; s < STAGES; s++) begin
        vld_d[s] = src_v[s];
        if (src_v[s]) begin
          a_d[s]   = src_a[s] >> SW;
          b_d[s]   = src_b[s] >> SW;
          sum_d[s] = (src_sum[s] >> SW) | (WIDTH'(res[s][SW-1:0]) << (WIDTH - SW));
          cy_d[s]  = res[s][SW+1];
        end
      end
      if (src_v[LAST]) begin
        ovf_d  = res[LAST][SW] ^ res[LAST][SW+1];
        zero_d = ~|sum_d[LAST];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= '0;
      cy_q   <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      for (int s = 0; s < STAGES; s++) begin
        sum_q[s] <= '0;
        a_q[s]   <= '0;
        b_q[s]   <= '0;
      end
    end else begin
      vld_q  <= vld_d;
      cy_q   <= cy_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
      for (int s = 0; s < STAGES; s++) begin
        sum_q[s] <= sum_d[s];
        a_q[s]   <= a_d[s];
        b_q[s]   <= b_d[s];
      end
    end
  end

endmodule
